fpmult_arbiter: RTL and testbench
=================================

FPMULT_ARBITER -- requirements
Module: fpmult_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one multiplier (2..8).
REQ-002 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  NREQ  per-requester request level; held until that requester's grant pulse.
REQ-005 Port: dataa  input  32*NREQ  operand A per requester, slice i = [32i+31:32i]; stable while req[i] high.
REQ-006 Port: datab  input  32*NREQ  operand B per requester, same slicing.
REQ-007 Port: grant  output  NREQ  one-hot, one-cycle pulse marking result valid for that requester.
REQ-008 Port: result  output  32  IEEE-754 single product; valid only in the grant cycle.
REQ-009 Port: busy  output  1  high in every state except IDLE.

Function
REQ-010 States: IDLE, START, WAIT, DONE; 2-bit encoding.
REQ-011 IDLE: if any req bit high, latch winner index and its operands, go to START; else stay.
REQ-012 START: drive multiplier reset high for exactly one cycle with latched operands; go to WAIT.
REQ-013 WAIT: ignore multiplier done in the first WAIT cycle (guard); thereafter on done=1 latch product, go to DONE.
REQ-014 DONE: grant[winner]=1, result=latched product for one cycle; go to IDLE.
REQ-015 Request-to-grant latency = multiplier latency + 4 cycles; back-to-back grants separated by at least 4 cycles.
REQ-016 Requester drops req in the cycle after its grant; a req still high in IDLE is re-served as a new operation.
REQ-017 req deasserted mid-operation: operation completes, grant still pulses; requester ignores it.
REQ-018 Operands latched in IDLE; changes on dataa/datab afterward do not affect the in-flight product.
REQ-019 Simultaneous requests: exactly one winner per IDLE cycle per REQ-026; losers wait, never dropped.
REQ-020 grant is zero in all states except DONE; result holds last product otherwise.

Reset
REQ-021 reset=1 forces IDLE on the next edge regardless of current state, including mid-WAIT.
REQ-022 Reset values: grant=0, busy=0, result=32'h0, winner index=0, round-robin pointer=0, multiplier reset=0.
REQ-023 An operation aborted by reset produces no grant; a late multiplier done is ignored in IDLE.
REQ-024 First request after reset release accepted in the first IDLE cycle.

Configuration
REQ-025 Macro FPMULT_ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-026 Defined: round-robin; search starts at index after last winner, wrapping NREQ-1 to 0; pointer updates only on win. Undefined: fixed priority, lowest index wins, no pointer logic.

Structure
REQ-027 Shared package holds state encoding constants, NREQ default, and FP constant 32'h3f800000.
REQ-028 Exactly one sub-module: existing fpmult (dataa, datab, reset, clk, result, done), instantiated once.
REQ-029 Winner selection is a combinational function inside this module, not a separate module.

Verification
REQ-030 Single req[0], A=32'h40000000 (2.0), B=32'h40400000 (3.0) -> one grant[0] pulse, result=32'h40c00000 (6.0), busy low next cycle.
REQ-031 req=4'b1111 held, each drops after grant, RR_EN defined -> grant order 0,1,2,3, each product correct.
REQ-032 Same stimulus with RR_EN undefined, req[0] reasserted after its grant -> req[0] served repeatedly; req[1] served only once req[0] stays low.
REQ-033 reset asserted in second WAIT cycle -> no grant, busy=0 next cycle, next request completes normally.
REQ-034 dataa[0] changed to 32'h0 during WAIT -> result still 32'h40c00000.
REQ-035 A=32'hbf800000 (-1.0), B=32'h3f800000 (1.0) on req[2] -> grant[2], result=32'hbf800000.

Source files
------------

// File: rtl/fpmult_arbiter_pkg.sv
// Shared constants, FSM encoding and the IEEE-754 single-precision multiply function
// used by the fpmult_arbiter block and its multiplier.
package fpmult_arbiter_pkg;

  localparam int unsigned NREQ_DEFAULT = 4;
  localparam int unsigned FP_W         = 32;
  localparam int unsigned MULT_LAT     = 3;
  localparam logic [FP_W-1:0] FP_ONE   = 32'h3f800000;
  localparam logic [FP_W-1:0] FP_QNAN  = 32'h7fc00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Round-to-nearest-even product; denormal inputs and underflow flush to signed zero.
  function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic              sign;
    logic [7:0]        ea, eb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       prod;
    logic signed [9:0] exp;
    logic [23:0]       mant;
    logic [24:0]       mant_rnd;
    logic              guard, sticky;
    logic [FP_W-1:0]   res;

    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hff) && (a[22:0] == 23'h0);
    b_inf  = (eb == 8'hff) && (b[22:0] == 23'h0);
    a_nan  = (ea == 8'hff) && (a[22:0] != 23'h0);
    b_nan  = (eb == 8'hff) && (b[22:0] != 23'h0);

    prod = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    exp  = 10'($signed({2'b00, ea})) + 10'($signed({2'b00, eb})) - 10'sd127;

    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp    = exp + 10'sd1;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    mant_rnd = {1'b0, mant} + 25'(guard & (sticky | mant[0]));
    if (mant_rnd[24]) begin
      mant = mant_rnd[24:1];
      exp  = exp + 10'sd1;
    end else begin
      mant = mant_rnd[23:0];
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res = FP_QNAN;
    end else if (a_inf || b_inf) begin
      res = {sign, 8'hff, 23'h0};
    end else if (a_zero || b_zero) begin
      res = {sign, 31'h0};
    end else if (exp >= 10'sd255) begin
      res = {sign, 8'hff, 23'h0};
    end else if (exp <= 10'sd0) begin
      res = {sign, 31'h0};
    end else begin
      res = {sign, exp[7:0], mant[22:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/fpmult_fpmult.sv
// Multi-cycle single-precision multiplier: reset restarts it, done rises MULT_LAT
// cycles later and stays high with the product until the next reset.
module fpmult
  import fpmult_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [FP_W-1:0] dataa,
  input  logic [FP_W-1:0] datab,
  output logic [FP_W-1:0] result,
  output logic            done
);

  localparam int unsigned CNT_W = $clog2(MULT_LAT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [FP_W-1:0]  r_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (r_cnt != CNT_W'(MULT_LAT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(MULT_LAT - 1)) begin
        r_done   <= 1'b1;
        r_result <= fp_mul(dataa, datab);
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: rtl/fpmult_arbiter.sv
// Shares one fpmult among NREQ requesters. Arbitration is fixed priority (lowest index)
// unless FPMULT_ARB_ROUND_ROBIN_EN is defined, which selects round-robin.
module fpmult_arbiter
  import fpmult_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [FP_W*NREQ-1:0] dataa,
  input  logic [FP_W*NREQ-1:0] datab,
  output logic [NREQ-1:0]      grant,
  output logic [FP_W-1:0]      result,
  output logic                 busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_winner;
  logic [FP_W-1:0]  r_opa;
  logic [FP_W-1:0]  r_opb;
  logic             r_mult_rst;
  logic             r_guard;

  logic [FP_W-1:0]  w_opa_arr [NREQ];
  logic [FP_W-1:0]  w_opb_arr [NREQ];
  logic [FP_W-1:0]  w_mult_result;
  logic             w_mult_done;
  logic [IDX_W-1:0] w_pick;

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_slice
    assign w_opa_arr[g] = dataa[FP_W*g +: FP_W];
    assign w_opb_arr[g] = datab[FP_W*g +: FP_W];
  end

`ifdef FPMULT_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_rr_ptr;

  // First requester at or after the start index, wrapping NREQ-1 to 0.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                   input logic [IDX_W-1:0] start);
    int unsigned idx;
    logic        found;
    pick_winner = start;
    found       = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && r[IDX_W'(idx)]) begin
        pick_winner = IDX_W'(idx);
        found       = 1'b1;
      end
    end
  endfunction

  assign w_pick = pick_winner(req, r_rr_ptr);
`else
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NREQ-1:0] r);
    pick_winner = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (r[IDX_W'(k)]) pick_winner = IDX_W'(k);
    end
  endfunction

  assign w_pick = pick_winner(req);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_winner   <= '0;
      r_mult_rst <= 1'b0;
      r_guard    <= 1'b0;
      grant      <= '0;
      result     <= '0;
      busy       <= 1'b0;
`ifdef FPMULT_ARB_ROUND_ROBIN_EN
      r_rr_ptr   <= '0;
`endif
    end else begin
      grant      <= '0;
      r_mult_rst <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_winner   <= w_pick;
            r_mult_rst <= 1'b1;
            busy       <= 1'b1;
            r_state    <= ST_START;
`ifdef FPMULT_ARB_ROUND_ROBIN_EN
            r_rr_ptr   <= (w_pick == IDX_W'(NREQ - 1)) ? '0 : w_pick + IDX_W'(1);
`endif
          end
        end
        ST_START: begin
          r_guard <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done left over from an earlier operation may still be visible here.
          r_guard <= 1'b0;
          if (!r_guard && w_mult_done) begin
            result  <= w_mult_result;
            grant   <= NREQ'(1) << r_winner;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand capture only; the multiplier reads them until the next winner is chosen.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && (|req)) begin
      r_opa <= w_opa_arr[w_pick];
      r_opb <= w_opb_arr[w_pick];
    end
  end

  fpmult u_fpmult (
    .clk    (clk),
    .reset  (r_mult_rst),
    .dataa  (r_opa),
    .datab  (r_opb),
    .result (w_mult_result),
    .done   (w_mult_done)
  );

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Directed bench for fpmult_arbiter; expectations follow the arbitration policy
// selected by FPMULT_ARB_ROUND_ROBIN_EN.
module tb_fpmult_arbiter;
  import fpmult_arbiter_pkg::*;

  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] dataa;
  logic [32*N-1:0] datab;
  logic [N-1:0]    grant;
  logic [31:0]     result;
  logic            busy;

  logic [31:0] a_arr [N];
  logic [31:0] b_arr [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Per-requester operands and hand-computed products: 2*3, 2*2, -1*1, 2*1.5
  logic [31:0] opa_t [N] = '{32'h40000000, 32'h40000000, 32'hbf800000, 32'h40000000};
  logic [31:0] opb_t [N] = '{32'h40400000, 32'h40000000, 32'h3f800000, 32'h3fc00000};
  logic [31:0] exp_t [N] = '{32'h40c00000, 32'h40800000, 32'hbf800000, 32'h40400000};

  for (genvar g = 0; g < int'(N); g++) begin : g_pack
    assign dataa[32*g +: 32] = a_arr[g];
    assign datab[32*g +: 32] = b_arr[g];
  end

  fpmult_arbiter #(.NREQ(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .dataa  (dataa),
    .datab  (datab),
    .grant  (grant),
    .result (result),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    for (int i = 0; i < int'(N); i++) begin
      a_arr[2'(i)] = opa_t[2'(i)];
      b_arr[2'(i)] = opb_t[2'(i)];
    end
  endtask

  // Waits (bounded) for a grant pulse; returns at the negedge of that cycle.
  task automatic wait_grant(output logic [N-1:0] g, output logic [31:0] r, output bit to);
    to = 1'b1;
    g  = '0;
    r  = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (grant !== '0) begin
        g  = grant;
        r  = result;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    load_all();
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] g;
    logic [31:0]  r;
    bit           to;
    a_arr[0] = 32'h40000000;
    b_arr[0] = 32'h40400000;
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL first_req_accept: busy %b expected 1", busy); end
    wait_grant(g, r, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: no grant expected 0001"); end
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", g); end
    checks++;
    if (r !== 32'h40c00000) begin errors++; $display("FAIL single_result: got %h expected 40c00000", r); end
    step();
    req = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL single_pulse: got %b expected 0000", grant); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    checks++;
    if (result !== 32'h40c00000) begin errors++; $display("FAIL single_hold: got %h expected 40c00000", result); end
    step();
  endtask

  task automatic test_negative();
    logic [N-1:0] g;
    logic [31:0]  r;
    bit           to;
    a_arr[2] = 32'hbf800000;
    b_arr[2] = FP_ONE;
    req = 4'b0100;
    wait_grant(g, r, to);
    checks++;
    if (to || g !== 4'b0100) begin errors++; $display("FAIL neg_grant: got %b expected 0100", g); end
    checks++;
    if (r !== 32'hbf800000) begin errors++; $display("FAIL neg_result: got %h expected bf800000", r); end
    step();
    req = '0;
    step();
  endtask

  task automatic test_rounding();
    logic [N-1:0] g;
    logic [31:0]  r;
    bit           to;
    // (1+2^-23)*1.5 is an exact tie; nearest-even rounds the odd mantissa up
    a_arr[3] = 32'h3f800001;
    b_arr[3] = 32'h3fc00000;
    req = 4'b1000;
    wait_grant(g, r, to);
    checks++;
    if (to || g !== 4'b1000) begin errors++; $display("FAIL round_grant: got %b expected 1000", g); end
    checks++;
    if (r !== 32'h3fc00002) begin errors++; $display("FAIL round_result: got %h expected 3fc00002", r); end
    step();
    req = '0;
    step();
  endtask

  task automatic test_operand_change();
    logic [N-1:0] g;
    logic [31:0]  r;
    bit           to;
    a_arr[0] = 32'h40000000;
    b_arr[0] = 32'h40400000;
    req = 4'b0001;
    repeat (3) step();
    a_arr[0] = 32'h0;
    wait_grant(g, r, to);
    checks++;
    if (to || g !== 4'b0001) begin errors++; $display("FAIL opchg_grant: got %b expected 0001", g); end
    checks++;
    if (r !== 32'h40c00000) begin errors++; $display("FAIL opchg_result: got %h expected 40c00000", r); end
    step();
    req = '0;
    a_arr[0] = 32'h40000000;
    step();
  endtask

  task automatic test_mid_drop();
    logic [N-1:0] g;
    logic [31:0]  r;
    bit           to;
    a_arr[1] = 32'h40000000;
    b_arr[1] = 32'h40000000;
    req = 4'b0010;
    repeat (2) step();
    req = '0;
    wait_grant(g, r, to);
    checks++;
    if (to || g !== 4'b0010) begin errors++; $display("FAIL middrop_grant: got %b expected 0010", g); end
    checks++;
    if (r !== 32'h40800000) begin errors++; $display("FAIL middrop_result: got %h expected 40800000", r); end
    step();
    step();
  endtask

  task automatic test_reset_abort();
    logic [N-1:0] g;
    logic [31:0]  r;
    bit           to;
    int           pulses;
    load_all();
    req = 4'b0001;
    repeat (3) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_wait: got %b expected 1", busy); end
    reset = 1'b1;
    req   = '0;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h expected 00000000", result); end
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (grant !== '0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL abort_no_grant: got %0d pulses expected 0", pulses); end
    step();
    req = 4'b1000;
    wait_grant(g, r, to);
    checks++;
    if (to || g !== 4'b1000) begin errors++; $display("FAIL abort_recover_grant: got %b expected 1000", g); end
    checks++;
    if (r !== 32'h40400000) begin errors++; $display("FAIL abort_recover_result: got %h expected 40400000", r); end
    step();
    req = '0;
    step();
  endtask

  task automatic test_all_requests();
    logic [N-1:0] g;
    logic [31:0]  r;
    bit           to;
    int           order[$];
    int           last_cyc;
    int           idx;
    int           remaining;
`ifdef FPMULT_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 2, 3};
`else
    // Requester 0 keeps its request up for three serves and starves the others meanwhile
    order = '{0, 0, 0, 1, 2, 3};
`endif
    load_all();
    req = 4'b1111;
    last_cyc = -100;
    for (int n = 0; n < order.size(); n++) begin
      idx = order[n];
      wait_grant(g, r, to);
      checks++;
      if (to || g !== (4'b0001 << idx)) begin
        errors++;
        $display("FAIL all_grant_%0d: got %b expected %b", n, g, 4'b0001 << idx);
      end
      checks++;
      if (r !== exp_t[2'(idx)]) begin
        errors++;
        $display("FAIL all_result_%0d: got %h expected %h", n, r, exp_t[2'(idx)]);
      end
      checks++;
      if (cyc - last_cyc < 4) begin
        errors++;
        $display("FAIL all_gap_%0d: got %0d cycles expected at least 4", n, cyc - last_cyc);
      end
      last_cyc = cyc;
      remaining = 0;
      for (int m = n + 1; m < order.size(); m++) if (order[m] == idx) remaining++;
      step();
      if (remaining == 0) req[2'(idx)] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req !== 4'b0000) begin
      errors++;
      $display("FAIL all_idle: busy %b req %b expected 0 0000", busy, req);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_rounding();
    test_operand_change();
    test_mid_drop();
    test_reset_abort();
    test_all_requests();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
